// File: rtl/register_file_nbit_2r1w_if.sv
// ----------------------------------------------------------------------------
// register_file_nbit_2r1w_if
//
// Bundles the operand/result bus of the register file. Decode drives the read
// ports and the Mark strobe. Writeback drives WS/WAddr/In. The register file
// returns registered read data and busy status.
//
// Signals:
//   WS, WAddr, In          write strobe, address and data
//   ReadA, RAddrA          read enable and address, port A
//   ReadB, RAddrB          read enable and address, port B
//   Mark, MarkAddr         set busy bit of MarkAddr (write pending)
//   OutA, OutB             registered read data
//   BusyA, BusyB           registered busy status of the entry read
//
// Modports:
//   master  the requester side (decode/writeback, or a testbench)
//   slave   the register file itself
//
// There is no handshake on this bus. Every strobe (WS, Mark, ReadA, ReadB)
// acts on the rising edge where it is high, and it is always accepted. Read
// results appear after that edge and hold until the next enabled read.
// ----------------------------------------------------------------------------
interface register_file_nbit_2r1w_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              WS;
    logic [ADDR_W-1:0] WAddr;
    logic [WIDTH-1:0]  In;
    logic              ReadA;
    logic [ADDR_W-1:0] RAddrA;
    logic              ReadB;
    logic [ADDR_W-1:0] RAddrB;
    logic              Mark;
    logic [ADDR_W-1:0] MarkAddr;
    logic [WIDTH-1:0]  OutA;
    logic [WIDTH-1:0]  OutB;
    logic              BusyA;
    logic              BusyB;

    modport master (
        output WS, WAddr, In, ReadA, RAddrA, ReadB, RAddrB, Mark, MarkAddr,
        input  OutA, OutB, BusyA, BusyB
    );

    modport slave (
        input  WS, WAddr, In, ReadA, RAddrA, ReadB, RAddrB, Mark, MarkAddr,
        output OutA, OutB, BusyA, BusyB
    );
endinterface

// File: rtl/register_file_nbit_2r1w.sv
// ----------------------------------------------------------------------------
// register_file_nbit_2r1w
//
// The register file has WIDTH bits by 2^ADDR_W entries. It has one write port
// and two registered read ports. Each entry has a busy bit that records a
// pending write.
// A read in the same cycle as a write or mark to the same entry returns the
// post-edge value (bypass). When ZERO_REG=1, entry 0 reads as zero, ignores
// writes and is never busy.
//
// Ports:
//   Clk    rising-edge clock
//   Reset  synchronous, active-high. Clears entries, busy bits and outputs.
//          It overrides every strobe in the same cycle.
//   bus    register_file_nbit_2r1w_if.slave (write, read, mark, outputs)
// ----------------------------------------------------------------------------
module register_file_nbit_2r1w #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input logic                        Clk,
    input logic                        Reset,
    register_file_nbit_2r1w_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic             busy_a_q, busy_a_d;
    logic             busy_b_q, busy_b_d;

    logic wr_en;
    logic mk_en;
    logic zero_a;
    logic zero_b;

    // The hard-wired zero entry filters out writes and marks at the source.
    // This keeps entry 0 at its reset value of zero.
    assign wr_en  = bus.WS   && !(ZERO_REG && (bus.WAddr    == '0));
    assign mk_en  = bus.Mark && !(ZERO_REG && (bus.MarkAddr == '0));
    assign zero_a = ZERO_REG && (bus.RAddrA == '0);
    assign zero_b = ZERO_REG && (bus.RAddrB == '0);

    // Next-state storage. The mark is applied after the write's busy clear.
    // A new producer marked in the same cycle supersedes the completing one.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_en) begin
            mem_d[bus.WAddr]  = bus.In;
            busy_d[bus.WAddr] = 1'b0;
        end
        if (mk_en) begin
            busy_d[bus.MarkAddr] = 1'b1;
        end
    end

    // The read ports sample the next-state view. A same-cycle write or mark to
    // the same entry is therefore bypassed without a separate compare path.
    always_comb begin
        out_a_d  = out_a_q;
        busy_a_d = busy_a_q;
        if (bus.ReadA) begin
            if (zero_a) begin
                out_a_d  = '0;
                busy_a_d = 1'b0;
            end else begin
                out_a_d  = mem_d[bus.RAddrA];
                busy_a_d = busy_d[bus.RAddrA];
            end
        end
    end

    always_comb begin
        out_b_d  = out_b_q;
        busy_b_d = busy_b_q;
        if (bus.ReadB) begin
            if (zero_b) begin
                out_b_d  = '0;
                busy_b_d = 1'b0;
            end else begin
                out_b_d  = mem_d[bus.RAddrB];
                busy_b_d = busy_d[bus.RAddrB];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q   <= '0;
            out_a_q  <= '0;
            out_b_q  <= '0;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            busy_q   <= busy_d;
            out_a_q  <= out_a_d;
            out_b_q  <= out_b_d;
            busy_a_q <= busy_a_d;
            busy_b_q <= busy_b_d;
        end
    end

    assign bus.OutA  = out_a_q;
    assign bus.OutB  = out_b_q;
    assign bus.BusyA = busy_a_q;
    assign bus.BusyB = busy_b_q;
endmodule
